// File: rtl/pie_pkg.sv
// Shared definitions for the PIE decoder and its companion encoder.
// - state_t     : decoder FSM state encoding
// - CNT_W_DEF   : default width of every length counter
// - *_DEF       : default PIE timings in clk cycles (delimiter, data-0,
//                 data-1, RTcal, TRcal, low pulse width)
package pie_pkg;

    localparam int CNT_W_DEF = 13;

    localparam int DELIM_DEF = 312;
    localparam int TARI_DEF  = 500;
    localparam int DATA1_DEF = 875;
    localparam int RTCAL_DEF = 1375;
    localparam int TRCAL_DEF = 4000;
    localparam int PW_DEF    = 250;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DELIM       = 3'd1,
        TARI        = 3'd2,
        RTCAL       = 3'd3,
        CAL_OR_DATA = 3'd4,
        DATA        = 3'd5
    } state_t;

endpackage

// File: rtl/pie_decoder_if.sv
// Bundle of the PIE decoder line input and its decoded outputs.
// - in_pie                               : raw PIE line (high = carrier)
// - out_dat/out_vld                      : decoded bit and its strobe
// - frame_start/frame_end/err            : one-cycle frame event pulses
// - tari_len/rtcal_len/trcal_len         : captured calibration lengths
// - trcal_vld                            : current frame carried TRcal
// master = decoder side, slave = line driver / consumer side.
interface pie_decoder_if #(
    parameter int CNT_W = 13
);
    logic             in_pie;
    logic             out_dat;
    logic             out_vld;
    logic             frame_start;
    logic             frame_end;
    logic             err;
    logic [CNT_W-1:0] tari_len;
    logic [CNT_W-1:0] rtcal_len;
    logic [CNT_W-1:0] trcal_len;
    logic             trcal_vld;

    modport master (
        input  in_pie,
        output out_dat, out_vld, frame_start, frame_end, err,
        output tari_len, rtcal_len, trcal_len, trcal_vld
    );

    modport slave (
        output in_pie,
        input  out_dat, out_vld, frame_start, frame_end, err,
        input  tari_len, rtcal_len, trcal_len, trcal_vld
    );
endinterface

// File: rtl/pie_edge_sync.sv
// Two-flop synchronizer for the asynchronous PIE line followed by an edge
// register. All flops reset to line-low, so a line that is already high when
// reset is released shows up as one rise (ignored by the decoder in IDLE).
// - clk, rst : clock, asynchronous active-high reset
// - din      : asynchronous line
// - lvl      : synchronized line level, aligned with rise/fall
// - rise     : one-cycle pulse on a low-to-high transition
// - fall     : one-cycle pulse on a high-to-low transition
module pie_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_reg;
    logic       lvl_reg;
    logic       rise_reg;
    logic       fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
            lvl_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            lvl_reg  <= sync_reg[1];
            rise_reg <= sync_reg[1] & ~lvl_reg;
            fall_reg <= ~sync_reg[1] & lvl_reg;
        end
    end

    assign lvl  = lvl_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
endmodule

// File: rtl/pie_decoder.sv
// PIE decoder: measures rise-to-rise symbol lengths, recovers the frame
// calibration (data-0, RTcal, optional TRcal) and slices data symbols
// against RTcal/2.
// - clk, rst : clock, asynchronous active-high reset
// - bus      : line input and all decoded outputs (pie_decoder_if.master)
module pie_decoder
    import pie_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DELIM_MIN   = 280,
    parameter int DELIM_MAX   = 1000,
    parameter int IDLE_CYCLES = 6000
) (
    input  logic          clk,
    input  logic          rst,
    pie_decoder_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DMIN     = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DMAX     = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);

    logic line_lvl, rise, fall;

    pie_edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.in_pie),
        .lvl  (line_lvl),
        .rise (rise),
        .fall (fall)
    );

    state_t           state_reg, state_next;
    // cnt_reg: duration of the current line level; sym_reg: cycles since
    // the last rise, i.e. the full symbol length (high plus low portion).
    logic [CNT_W-1:0] cnt_reg, sym_reg;
    logic [CNT_W-1:0] tari_reg, tari_next;
    logic [CNT_W-1:0] rtcal_reg, rtcal_next;
    logic [CNT_W-1:0] trcal_reg, trcal_next;
    logic             trcal_vld_reg, trcal_vld_next;
    logic             bits_seen_reg, bits_seen_next;
    logic             dat_reg, dat_next;
    logic             vld_reg, vld_next;
    logic             start_reg, start_next;
    logic             end_reg, end_next;
    logic             err_reg, err_next;

    logic             low_delim, high_timeout, in_frame, do_slice;
    logic [CNT_W-1:0] pivot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sym_reg       <= '0;
            tari_reg      <= '0;
            rtcal_reg     <= '0;
            trcal_reg     <= '0;
            trcal_vld_reg <= 1'b0;
            bits_seen_reg <= 1'b0;
            dat_reg       <= 1'b0;
            vld_reg       <= 1'b0;
            start_reg     <= 1'b0;
            end_reg       <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (rise || fall)
                cnt_reg <= CNT_ONE;
            else if (cnt_reg != CNT_SAT)
                cnt_reg <= cnt_reg + CNT_ONE;

            if (rise)
                sym_reg <= CNT_ONE;
            else if (sym_reg != CNT_SAT)
                sym_reg <= sym_reg + CNT_ONE;

            tari_reg      <= tari_next;
            rtcal_reg     <= rtcal_next;
            trcal_reg     <= trcal_next;
            trcal_vld_reg <= trcal_vld_next;
            bits_seen_reg <= bits_seen_next;
            dat_reg       <= dat_next;
            vld_reg       <= vld_next;
            start_reg     <= start_next;
            end_reg       <= end_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tari_next      = tari_reg;
        rtcal_next     = rtcal_reg;
        trcal_next     = trcal_reg;
        trcal_vld_next = trcal_vld_reg;
        bits_seen_next = bits_seen_reg;
        dat_next       = 1'b0;
        vld_next       = 1'b0;
        start_next     = 1'b0;
        end_next       = 1'b0;
        err_next       = 1'b0;
        do_slice       = 1'b0;

        pivot        = rtcal_reg >> 1;
        // A rise always takes precedence: low_delim cannot coincide with a
        // rise (line is high then) and high_timeout excludes it explicitly.
        low_delim    = !line_lvl && !fall && (cnt_reg == DMIN);
        high_timeout = line_lvl && !rise && (cnt_reg == IDLE_LIM);
        in_frame     = state_reg inside {TARI, RTCAL, CAL_OR_DATA, DATA};

        case (state_reg)
            IDLE: begin
                if (fall)
                    state_next = DELIM;
            end
            DELIM: begin
                if (cnt_reg > DMAX) begin
                    state_next = IDLE;
                end else if (rise) begin
                    if (cnt_reg >= DMIN) begin
                        state_next     = TARI;
                        trcal_vld_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            TARI: begin
                if (rise) begin
                    tari_next  = sym_reg;
                    state_next = RTCAL;
                end
            end
            RTCAL: begin
                if (rise) begin
                    if (sym_reg <= tari_reg) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        rtcal_next     = sym_reg;
                        start_next     = 1'b1;
                        bits_seen_next = 1'b0;
                        state_next     = CAL_OR_DATA;
                    end
                end
            end
            CAL_OR_DATA: begin
                if (rise) begin
                    if (sym_reg > rtcal_reg) begin
                        trcal_next     = sym_reg;
                        trcal_vld_next = 1'b1;
                        state_next     = DATA;
                    end else begin
                        do_slice = 1'b1;
                    end
                end
            end
            DATA: begin
                if (rise)
                    do_slice = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (do_slice) begin
            if (sym_reg >= rtcal_reg) begin
                err_next   = 1'b1;
                state_next = IDLE;
            end else begin
                vld_next       = 1'b1;
                dat_next       = (sym_reg > pivot);
                bits_seen_next = 1'b1;
                state_next     = DATA;
            end
        end

        // Frame aborts: a long low is a fresh delimiter (cnt keeps running
        // into DELIM); a long high ends the frame.
        if (in_frame && low_delim) begin
            err_next   = 1'b1;
            state_next = DELIM;
        end else if (in_frame && high_timeout) begin
            state_next = IDLE;
            if ((state_reg == DATA) && bits_seen_reg)
                end_next = 1'b1;
            else
                err_next = 1'b1;
        end
    end

    assign bus.out_dat     = dat_reg;
    assign bus.out_vld     = vld_reg;
    assign bus.frame_start = start_reg;
    assign bus.frame_end   = end_reg;
    assign bus.err         = err_reg;
    assign bus.tari_len    = tari_reg;
    assign bus.rtcal_len   = rtcal_reg;
    assign bus.trcal_len   = trcal_reg;
    assign bus.trcal_vld   = trcal_vld_reg;
endmodule
